regfile_banked: RTL and testbench



---
 rtl/regfile_banked.sv | 96 +++++++++
 tb/tb_regfile_banked.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_banked.sv
// Multi-read-port register file with byte-lane writes, same-cycle write bypass
// and a per-register scoreboard busy bit.
module regfile_banked #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned NB      = DATA_W / 8;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DATA_W-1:0] row_d;
    logic              wr_live;

    assign wr_live = rst_n && wr_en;

    // Byte-merged image of the row being written.
    always_comb begin
        row_d = regs_q[wr_addr];
        for (int unsigned k = 0; k < NB; k++) begin
            if (wr_be[k]) begin
                row_d[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // Set is applied after clear so a new producer on the written index wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_en && !(ZERO_EN && (wr_addr == '0))) begin
                regs_q[wr_addr] <= row_d;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;
        logic              zero_idx;
        logic              hit;
        logic              busy;

        always_comb begin
            ra       = rd_addr[p*ADDR_W +: ADDR_W];
            zero_idx = ZERO_EN && (ra == '0);
            hit      = wr_live && (wr_addr == ra);
            rd_val   = zero_idx ? '0 : regs_q[ra];
            for (int unsigned k = 0; k < NB; k++) begin
                if (hit && !zero_idx && wr_be[k]) begin
                    rd_val[8*k +: 8] = wr_data[8*k +: 8];
                end
            end
            busy = busy_q[ra] && !hit;
        end

        assign rd_data[p*DATA_W +: DATA_W] = rd_val;
        assign rd_busy[p]                  = busy;
    end

endmodule

// File: tb/tb_regfile_banked.sv
// Randomized and directed checks of regfile_banked against a behavioural
// register/busy model held in plain arrays.
module tb_regfile_banked;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR*AW-1:0]    rd_addr;
    logic [NR*DW-1:0]    rd_data;
    logic [NR-1:0]       rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [NB-1:0]       wr_be;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;

    logic [DW-1:0] ref_mem  [DEPTH];
    bit            ref_busy [DEPTH];
    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;

    always #5 clk = ~clk;

    regfile_banked #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RD  (NR),
        .ZERO_REG(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_busy(rd_busy),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be  (wr_be),
        .sb_set (sb_set),
        .sb_addr(sb_addr)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] exp_rd(input int a);
        logic [DW-1:0] v;
        v = (a == 0) ? '0 : ref_mem[a];
        if (rst_n && wr_en && (int'(wr_addr) == a) && a != 0)
            for (int k = 0; k < NB; k++)
                if (wr_be[k]) v[8*k +: 8] = wr_data[8*k +: 8];
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        return ref_busy[a] && !(rst_n && wr_en && (int'(wr_addr) == a));
    endfunction

    task automatic check_outputs(input string tag);
        int a;
        for (int p = 0; p < NR; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            check($sformatf("%s.data%0d@%0d", tag, p, a), rd_data[p*DW +: DW], exp_rd(a));
            check($sformatf("%s.busy%0d@%0d", tag, p, a), {31'd0, rd_busy[p]}, {31'd0, exp_busy(a)});
        end
    endtask

    // Advance one clock edge and apply the register-file rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i]  = '0;
                ref_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0)
                for (int k = 0; k < NB; k++)
                    if (wr_be[k]) ref_mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            if (wr_en) ref_busy[wr_addr] = 1'b0;
            if (sb_set && sb_addr != 0) ref_busy[sb_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic cyc(input string tag);
        #1;
        check_outputs(tag);
        tick();
    endtask

    task automatic idle();
        wr_en = 0; sb_set = 0; wr_be = '0; wr_data = '0; wr_addr = '0; sb_addr = '0;
    endtask

    function automatic logic [NR*AW-1:0] rd2(input int a0, input int a1);
        logic [AW-1:0] x0, x1;
        x0 = AW'(a0);
        x1 = AW'(a1);
        return {x1, x0};
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = 32'hBAD0BAD0;
            ref_busy[i] = 1'b1;
        end
        rst_n = 0; rd_addr = '0; idle();
        tick();
        tick();
        rst_n = 1;

        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = rd2(i, DEPTH - 1 - i);
            cyc("reset_scan");
        end

        // Full write then single-lane partial write
        rd_addr = rd2(5, 5);
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
        cyc("wr5_full");
        wr_data = 32'h000000AA; wr_be = 4'b0001;
        cyc("wr5_lane0");
        idle();
        #1;
        check("req033_const", rd_data[0 +: DW], 32'hDEADBEAA);
        cyc("rd5");

        // Same-cycle bypass with upper lanes only
        rd_addr = rd2(5, 7);
        wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; wr_be = 4'b1100;
        #1;
        check("req034_bypass", rd_data[DW +: DW], 32'h12340000);
        cyc("wr7_bypass");
        idle();

        // Scoreboard set, hazard visible, cleared by write in the same cycle
        sb_set = 1; sb_addr = 9; rd_addr = rd2(9, 9);
        cyc("sb9_set");
        idle();
        #1;
        check("req035_busy", {31'd0, rd_busy[0]}, 32'd1);
        cyc("sb9_pending");
        wr_en = 1; wr_addr = 9; wr_data = 32'h0BADF00D; wr_be = 4'b1111;
        #1;
        check("req035_bypass_busy", {31'd0, rd_busy[1]}, 32'd0);
        cyc("sb9_clear");
        idle();
        #1;
        check("req035_after", {31'd0, rd_busy[0]}, 32'd0);
        cyc("sb9_idle");

        // Set and write to one index on the same edge: set wins
        sb_set = 1; sb_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'hCAFEF00D; wr_be = 4'b1111;
        rd_addr = rd2(3, 9);
        cyc("sb3_wr3");
        idle();
        #1;
        check("req036_busy", {31'd0, rd_busy[0]}, 32'd1);
        check("req036_data", rd_data[0 +: DW], 32'hCAFEF00D);
        cyc("rd3");

        // Register zero stays zero and never busy
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
        sb_set = 1; sb_addr = 0; rd_addr = rd2(0, 0);
        cyc("wr0");
        idle();
        #1;
        check("req037_r0", rd_data[0 +: DW], 32'd0);
        check("req037_b0", {31'd0, rd_busy[1]}, 32'd0);
        cyc("rd0");

        // Reset with write/set asserted: both ignored, no bypass
        rst_n = 0; wr_en = 1; wr_addr = 4; wr_data = 32'h55AA55AA; wr_be = 4'b1111;
        sb_set = 1; sb_addr = 4; rd_addr = rd2(4, 3);
        #1;
        check("reset_nobypass", rd_data[0 +: DW], 32'd0);
        cyc("reset_wr");
        idle();
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = rd2(i, (i * 7) % DEPTH);
            cyc("post_reset_scan");
        end

        // Random traffic, mostly on a small index window to force aliasing
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow  = ($urandom_range(0, 3) != 0);
            rst_n   = ($urandom_range(0, 59) != 0);
            wr_en   = ($urandom_range(0, 1) != 0);
            sb_set  = ($urandom_range(0, 2) == 0);
            wr_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            sb_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_data = $urandom;
            wr_be   = NB'($urandom);
            rd_addr = narrow ? rd2($urandom_range(0, 7), $urandom_range(0, 7))
                             : rd2($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
